// File: rtl/mem_copy_engine_pkg.sv
// Shared memory handshake types and default configuration for the boot copy engine.
package mem_copy_engine_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_error;
  } mem_out_type;

  localparam logic [31:0] copy_src_base = 32'h0000_0000;
  localparam logic [31:0] copy_dst_base = 32'h8000_0000;
  localparam int unsigned copy_words    = 64;
  localparam int unsigned copy_timeout  = 255;

  // Byte address of a word; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] index);
    return base + {14'b0, index, 2'b00};
  endfunction

endpackage

// File: rtl/mem_copy_timer.sv
// Loadable down-counter; expire flags the last cycle a transfer may still wait.
module mem_copy_timer #(
  parameter int unsigned Width = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  output logic             expire
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count includes the request cycle, so expiry is signalled one cycle before zero.
  assign expire = (cnt_q <= Width'(1));

endmodule

// File: rtl/mem_copy_engine.sv
// Copies WORDS words from a source responder to a destination responder, one word at a time.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter logic [31:0] SRC_BASE = copy_src_base,
  parameter logic [31:0] DST_BASE = copy_dst_base,
  parameter int unsigned WORDS    = copy_words,
  parameter int unsigned TIMEOUT  = copy_timeout
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output mem_in_type  src_in,
  input  mem_out_type src_out,
  output mem_in_type  dst_in,
  input  mem_out_type dst_out,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] count
);

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdWait, StWrReq, StWrWait, StFinish, StFail
  } state_e;

  localparam logic [15:0] LastIndex = 16'(WORDS - 1);
  localparam logic [15:0] TimerLoad = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] index_q, index_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        timer_load, timer_expire;

  mem_copy_timer #(
    .Width(16)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (timer_load),
    .load_value(TimerLoad),
    .expire    (timer_expire)
  );

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRdReq;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          index_d = '0;
        end
      end
      StRdReq: state_d = StRdWait;
      StRdWait: begin
        if (src_out.mem_ready) begin
          if (src_out.mem_error) begin
            state_d = StFail;
          end else begin
            data_d  = src_out.mem_rdata;
            state_d = StWrReq;
          end
        end else if (timer_expire) begin
          state_d = StFail;
        end
      end
      StWrReq: state_d = StWrWait;
      StWrWait: begin
        if (dst_out.mem_ready) begin
          if (dst_out.mem_error) begin
            state_d = StFail;
          end else begin
            index_d = index_q + 16'd1;
            state_d = (index_q == LastIndex) ? StFinish : StRdReq;
          end
        end else if (timer_expire) begin
          state_d = StFail;
        end
      end
      StFinish: state_d = StIdle;
      StFail:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // Status flags are registered on entry so they are visible during FINISH/FAIL.
    if (state_d == StFinish) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
    if (state_d == StFail) begin
      error_d = 1'b1;
      busy_d  = 1'b0;
    end
  end

  assign timer_load = (state_d == StRdReq) || (state_d == StWrReq);

  always_comb begin
    src_in = '0;
    dst_in = '0;
    if (state_q == StRdReq || state_q == StRdWait) begin
      src_in.mem_valid = (state_q == StRdReq);
      src_in.mem_addr  = word_addr(SRC_BASE, index_q);
    end
    if (state_q == StWrReq || state_q == StWrWait) begin
      dst_in.mem_valid = (state_q == StWrReq);
      dst_in.mem_addr  = word_addr(DST_BASE, index_q);
      dst_in.mem_wdata = data_q;
      dst_in.mem_wstrb = 4'hF;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      index_q <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;
  assign count = index_q;

  logic unused_dst_rdata;
  assign unused_dst_rdata = ^dst_out.mem_rdata;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench: stimulus queues expected requests, a negedge monitor checks them.
module tb_mem_copy_engine;
  import mem_copy_engine_pkg::*;

  localparam logic [31:0] SrcBase = 32'h0000_0000;
  localparam logic [31:0] DstBase = 32'h8000_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  mem_in_type  src_in, dst_in;
  mem_out_type src_out = '0;
  mem_out_type dst_out = '0;
  logic        busy, done, error;
  logic [15:0] count;

  int checks = 0;
  int failures = 0;

  logic [31:0] rom [4];
  logic [31:0] src_q [$];
  wr_t         dst_q [$];

  int src_delay = 1;
  int dst_delay = 1;
  int src_err_idx = -1;
  bit dst_never = 1'b0;

  mem_copy_engine #(
    .SRC_BASE(SrcBase),
    .DST_BASE(DstBase),
    .WORDS   (4),
    .TIMEOUT (255)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .src_in (src_in),
    .src_out(src_out),
    .dst_in (dst_in),
    .dst_out(dst_out),
    .busy   (busy),
    .done   (done),
    .error  (error),
    .count  (count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source responder: ready src_delay cycles after the request cycle.
  initial begin
    int pend = 0;
    logic [31:0] addr = '0;
    forever begin
      @(posedge clock);
      #1;
      src_out = '0;
      if (!reset) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            int idx;
            idx = int'((addr - SrcBase) >> 2);
            src_out.mem_ready = 1'b1;
            src_out.mem_rdata = (idx < 4) ? rom[idx] : 32'hDEAD_BEEF;
            src_out.mem_error = (idx == src_err_idx);
          end
        end
        if (src_in.mem_valid) begin
          pend = src_delay;
          addr = src_in.mem_addr;
        end
      end
    end
  end

  // Destination responder: ready dst_delay cycles after the request, or never.
  initial begin
    int pend = 0;
    forever begin
      @(posedge clock);
      #1;
      dst_out = '0;
      if (!reset) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) dst_out.mem_ready = 1'b1;
        end
        if (dst_in.mem_valid && !dst_never) pend = dst_delay;
      end
    end
  end

  // Monitor: pops expectations on each request and checks hold-until-ready on writes.
  initial begin
    bit  prev_dvalid = 1'b0;
    bit  d_pend = 1'b0;
    wr_t cur = '{addr: '0, data: '0};
    forever begin
      @(negedge clock);
      if (reset) begin
        if (src_in.mem_valid) begin
          if (src_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL src unexpected read: got addr %0h expected none", src_in.mem_addr);
          end else begin
            logic [31:0] e;
            e = src_q.pop_front();
            check("src addr", src_in.mem_addr, e);
            check("src wstrb", 32'(src_in.mem_wstrb), 32'h0);
            check("src instr", 32'(src_in.mem_instr), 32'h0);
          end
        end
        if (dst_in.mem_valid) begin
          check("dst valid single cycle", 32'(prev_dvalid), 32'h0);
          if (dst_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL dst unexpected write: got addr %0h expected none", dst_in.mem_addr);
          end else begin
            cur = dst_q.pop_front();
            check("dst addr", dst_in.mem_addr, cur.addr);
            check("dst data", dst_in.mem_wdata, cur.data);
            check("dst wstrb", 32'(dst_in.mem_wstrb), 32'hF);
            d_pend = 1'b1;
          end
        end else if (d_pend && busy) begin
          check("dst addr held", dst_in.mem_addr, cur.addr);
          check("dst data held", dst_in.mem_wdata, cur.data);
          if (dst_out.mem_ready) d_pend = 1'b0;
        end
        if (!busy) d_pend = 1'b0;
      end else begin
        d_pend = 1'b0;
      end
      prev_dvalid = dst_in.mem_valid;
    end
  end

  task automatic push_src(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(SrcBase + 32'(4 * i));
  endtask

  task automatic push_dst(input int n);
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.addr = DstBase + 32'(4 * i);
      w.data = rom[i];
      dst_q.push_back(w);
    end
  endtask

  task automatic check_drained(input string name);
    check({name, " src queue empty"}, 32'(src_q.size()), 32'h0);
    check({name, " dst queue empty"}, 32'(dst_q.size()), 32'h0);
  endtask

  // Pulses start, then runs until done/error or the budget; cyc counts cycles from start.
  task automatic run_copy(input int budget, input int pulse_at, output int cyc,
                          output logic busy1, output logic done1);
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cyc   = 1;
    busy1 = busy;
    done1 = done;
    while (!(done || error) && cyc < budget) begin
      start = (cyc == pulse_at);
      @(posedge clock);
      #1 start = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   cyc;
    logic b1, d1;
    rom[0] = 32'h4101_4081;
    rom[1] = 32'h4201_4181;
    rom[2] = 32'h4301_4281;
    rom[3] = 32'h4401_4381;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    check("reset error", 32'(error), 32'h0);
    check("reset count", 32'(count), 32'h0);
    check("reset src valid", 32'(src_in.mem_valid), 32'h0);
    check("reset dst wstrb", 32'(dst_in.mem_wstrb), 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // T1: basic 4-word copy with 1-cycle responders
    push_src(4);
    push_dst(4);
    run_copy(200, -1, cyc, b1, d1);
    check("t1 done cycle", 32'(cyc), 32'd17);
    check("t1 done", 32'(done), 32'h1);
    check("t1 count", 32'(count), 32'd4);
    check("t1 busy", 32'(busy), 32'h0);
    check("t1 error", 32'(error), 32'h0);
    // start during FINISH is ignored
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    check("t1 finish start busy", 32'(busy), 32'h0);
    repeat (5) @(posedge clock);
    #1;
    check("t1 finish start idle", 32'(busy), 32'h0);
    check("t1 done sticky", 32'(done), 32'h1);
    check_drained("t1");

    // T2: slow destination, plus a start pulse while busy
    dst_delay = 5;
    push_src(4);
    push_dst(4);
    run_copy(300, 10, cyc, b1, d1);
    check("t2 done cycle", 32'(cyc), 32'd33);
    check("t2 done", 32'(done), 32'h1);
    check("t2 error", 32'(error), 32'h0);
    check("t2 count", 32'(count), 32'd4);
    check_drained("t2");
    dst_delay = 1;

    // T3: restart after done clears done and repeats the copy
    repeat (2) @(posedge clock);
    push_src(4);
    push_dst(4);
    run_copy(200, -1, cyc, b1, d1);
    check("t3 busy after start", 32'(b1), 32'h1);
    check("t3 done cleared", 32'(d1), 32'h0);
    check("t3 done cycle", 32'(cyc), 32'd17);
    check("t3 count", 32'(count), 32'd4);
    check_drained("t3");

    // T4: source error on word 2
    src_err_idx = 2;
    push_src(3);
    push_dst(2);
    run_copy(200, -1, cyc, b1, d1);
    check("t4 error cycle", 32'(cyc), 32'd11);
    check("t4 error", 32'(error), 32'h1);
    check("t4 done", 32'(done), 32'h0);
    check("t4 count", 32'(count), 32'd2);
    check("t4 busy", 32'(busy), 32'h0);
    repeat (4) @(posedge clock);
    check_drained("t4");
    src_err_idx = -1;

    // T5: destination never ready -> timeout 255 cycles after the write request
    dst_never = 1'b1;
    push_src(1);
    push_dst(1);
    run_copy(400, -1, cyc, b1, d1);
    check("t5 error cycle", 32'(cyc), 32'd258);
    check("t5 error", 32'(error), 32'h1);
    check("t5 done", 32'(done), 32'h0);
    check("t5 busy", 32'(busy), 32'h0);
    check("t5 count", 32'(count), 32'h0);
    check_drained("t5");
    dst_never = 1'b0;

    // T6: reset during RD_WAIT, then a fresh copy from index 0
    src_delay = 20;
    push_src(1);
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("t6 busy", 32'(busy), 32'h0);
    check("t6 error", 32'(error), 32'h0);
    check("t6 done", 32'(done), 32'h0);
    check("t6 count", 32'(count), 32'h0);
    check("t6 src addr", src_in.mem_addr, 32'h0);
    check("t6 dst valid", 32'(dst_in.mem_valid), 32'h0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    src_delay = 1;
    repeat (30) @(posedge clock);
    #1;
    check("t6 idle after reset", 32'(busy), 32'h0);
    check_drained("t6 reset");
    push_src(4);
    push_dst(4);
    run_copy(200, -1, cyc, b1, d1);
    check("t6 done cycle", 32'(cyc), 32'd17);
    check("t6 count after", 32'(count), 32'd4);
    check_drained("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
